bit_popcount_stream: RTL and testbench

- Streaming population counter for WIDTH-bit words.
- The count is split across NUM_STAGES pipeline stages. Each stage adds LANES_PER_STAGE bits of the word to a running partial count.
- Full valid/ready backpressure, so the block can be inserted into any stalled stream.
- A per-word mode bit selects counting ones or counting zeros. The original word and its mode travel with the count, so the downstream consumer sees both together.

---
 rtl/bit_popcount_stream_pkg.sv | 19 +
 rtl/bit_popcount_stream_if.sv | 35 +++
 rtl/bit_popcount_stream_stage.sv | 65 ++++++
 rtl/bit_popcount_stream.sv | 57 +++++
 tb/tb_bit_popcount_stream.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_popcount_stream_pkg.sv
// Shared helpers for the streaming popcount pipeline.
// Stage-count and count-width math plus mode encodings.
package bit_popcount_pkg;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  function automatic int num_stages(
    input int width,
    input int lanes
  );
    return (width + lanes - 1) / lanes;
  endfunction

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_popcount_stream_if.sv
// Stream bundle of the popcount block.
// The slave side is the block, the master side is its environment.
interface bit_popcount_stream_if
  import bit_popcount_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] data_i;
  logic             mode_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_o;
  logic             mode_o;
  logic [CW-1:0]    count_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;

  modport slave (
    input  data_i, mode_i, valid_i,
    input  ready_i,
    output ready_o, data_o, mode_o,
    output count_o, valid_o, busy_o
  );

  modport master (
    output data_i, mode_i, valid_i,
    output ready_i,
    input  ready_o, data_o, mode_o,
    input  count_o, valid_o, busy_o
  );

endinterface

// File: rtl/bit_popcount_stream_stage.sv
// One registered popcount stage: adds the bits it covers
// to the incoming partial count and carries word and mode.
module bit_popcount_stage
  import bit_popcount_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 8,
  parameter int OFFSET = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_mode,
  input  logic [cnt_w(WIDTH)-1:0]  i_count,
  output logic                     o_ready,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_mode,
  output logic [cnt_w(WIDTH)-1:0]  o_count
);

  localparam int CW = cnt_w(WIDTH);
  localparam int NB =
    (WIDTH - OFFSET < LANES) ? WIDTH - OFFSET : LANES;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_mode;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_add;
  logic             w_ready;

  // a covered bit counts when it differs from the mode bit
  always_comb begin
    w_add = '0;
    for (int i = 0; i < NB; i++) begin
      w_add = w_add + CW'(i_data[OFFSET+i] ^ i_mode);
    end
  end

  assign w_ready = ~r_valid | i_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= 1'b0;
      r_count <= '0;
    end else if (w_ready) begin
      r_valid <= i_valid;
      r_data  <= i_data;
      r_mode  <= i_mode;
      r_count <= i_count + w_add;
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_count = r_count;

endmodule

// File: rtl/bit_popcount_stream.sv
// Streaming population counter split over a chain of
// registered stages with a combinational ready chain.
module bit_popcount_stream
  import bit_popcount_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int LANES_PER_STAGE = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  bit_popcount_stream_if.slave bus
);

  localparam int NS = num_stages(WIDTH, LANES_PER_STAGE);
  localparam int CW = cnt_w(WIDTH);

  logic [NS:0]      w_vld;
  logic [NS:0]      w_rdy;
  logic             w_mode [NS+1];
  logic [WIDTH-1:0] w_dat  [NS+1];
  logic [CW-1:0]    w_cnt  [NS+1];

  assign w_vld[0]  = bus.valid_i;
  assign w_dat[0]  = bus.data_i;
  assign w_mode[0] = bus.mode_i;
  assign w_cnt[0]  = '0;
  assign w_rdy[NS] = bus.ready_i;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    bit_popcount_stage #(
      .WIDTH  (WIDTH),
      .LANES  (LANES_PER_STAGE),
      .OFFSET (k * LANES_PER_STAGE)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_valid (w_vld[k]),
      .i_data  (w_dat[k]),
      .i_mode  (w_mode[k]),
      .i_count (w_cnt[k]),
      .o_ready (w_rdy[k]),
      .i_ready (w_rdy[k+1]),
      .o_valid (w_vld[k+1]),
      .o_data  (w_dat[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_count (w_cnt[k+1])
    );
  end

  assign bus.ready_o = w_rdy[0];
  assign bus.valid_o = w_vld[NS];
  assign bus.data_o  = w_dat[NS];
  assign bus.mode_o  = w_mode[NS];
  assign bus.count_o = w_cnt[NS];
  assign bus.busy_o  = |w_vld[NS:1];

endmodule

// File: tb/tb_bit_popcount_stream.sv
// Bench for the streaming popcount: a queue model of the
// 32/8 pipe plus directed checks on a 13/5 instance.
module tb_bit_popcount_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_popcount_stream_if #(.WIDTH(32)) a ();
  bit_popcount_stream_if #(.WIDTH(13)) b ();

  bit_popcount_stream #(
    .WIDTH(32), .LANES_PER_STAGE(8)
  ) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(a));

  bit_popcount_stream #(
    .WIDTH(13), .LANES_PER_STAGE(5)
  ) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(b));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic        m;
    int          c;
  } exp_t;

  exp_t q[$];
  bit          stall = 0;
  logic [31:0] h_d;
  logic        h_m;
  logic [5:0]  h_c;
  int          n_out = 0;

  task automatic chk(input string nm,
                     input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic int ref_cnt(
    input logic [31:0] d, input int w, input logic m);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return m ? w - ones : ones;
  endfunction

  // compare process for the 32-bit instance
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_data", a.data_o, h_d);
        chk("hold_mode", a.mode_o, h_m);
        chk("hold_count", a.count_o, h_c);
      end
      if (a.valid_o && a.ready_i) begin
        exp_t e;
        n_out++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stale_out: got %0h expected none",
                   a.data_o);
        end else begin
          e = q.pop_front();
          chk("out_data", a.data_o, e.d);
          chk("out_mode", a.mode_o, e.m);
          chk("out_count", a.count_o, e.c);
        end
      end
      stall = a.valid_o && !a.ready_i;
      h_d = a.data_o;
      h_m = a.mode_o;
      h_c = a.count_o;
      if (a.valid_i && a.ready_o) begin
        exp_t e;
        e.d = a.data_i;
        e.m = a.mode_i;
        e.c = ref_cnt(a.data_i, 32, a.mode_i);
        q.push_back(e);
      end
    end
  end

  task automatic send_a(input logic [31:0] d,
                        input logic m);
    bit ok;
    ok = 0;
    a.data_i = d;
    a.mode_i = m;
    a.valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = a.ready_o;
      @(posedge clk);
      #1;
    end
    a.valid_i = 1'b0;
    if (!ok) chk("send_a_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [12:0] d,
                        input logic m);
    bit ok;
    ok = 0;
    b.data_i = d;
    b.mode_i = m;
    b.valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = b.ready_o;
      @(posedge clk);
      #1;
    end
    b.valid_i = 1'b0;
    if (!ok) chk("send_b_timeout", 0, 1);
  endtask

  task automatic lat_a(output int lat);
    lat = 1;
    while (!a.valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic lat_b(output int lat);
    lat = 1;
    while (!b.valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while ((a.busy_o || q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", n < 100, 1);
  endtask

  initial begin
    int lat, acc, gaps;
    logic [31:0] d;
    logic m;
    a.data_i = '0; a.mode_i = 0;
    a.valid_i = 0; a.ready_i = 1;
    b.data_i = '0; b.mode_i = 0;
    b.valid_i = 0; b.ready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a.valid_o, 0);
    chk("rst_busy", a.busy_o, 0);
    chk("rst_count", a.count_o, 0);
    chk("rst_data", a.data_o, 0);
    chk("rst_mode", a.mode_o, 0);
    chk("rst_ready", a.ready_o, 1);
    chk("rst_b_valid", b.valid_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // model pins
    chk("ref_ones", ref_cnt(32'hFFFF_FFFF, 32, 0), 32);
    chk("ref_zero", ref_cnt(32'h0000_00F0, 32, 1), 28);

    send_a(32'hFFFF_FFFF, 0);
    lat_a(lat);
    chk("lat_a", lat, 4);
    chk("all_ones_cnt", a.count_o, 32);
    chk("all_ones_dat", a.data_o, 32'hFFFF_FFFF);
    drain_a();

    send_a(32'h0000_00F0, 1);
    send_a(32'h0000_00F0, 0);
    lat_a(lat);
    chk("zmode_cnt", a.count_o, 28);
    chk("zmode_mode", a.mode_o, 1);
    @(posedge clk);
    #1;
    chk("omode_cnt", a.count_o, 4);
    chk("omode_mode", a.mode_o, 0);
    drain_a();

    gaps = 0;
    for (int i = 0; i < 100; i++) begin
      send_a($urandom, 1'($urandom));
      if (i >= 3) gaps += int'(!a.valid_o);
    end
    chk("stream_rate", gaps, 0);
    drain_a();

    a.ready_i = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      a.data_i = $urandom;
      a.mode_i = 1'($urandom);
      a.valid_i = 1;
      @(negedge clk);
      acc += int'(a.ready_o);
      @(posedge clk);
      #1;
    end
    a.valid_i = 0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", a.ready_o, 0);
    chk("bp_busy", a.busy_o, 1);
    a.ready_i = 1;
    #0;
    chk("bp_ready_comb", a.ready_o, 1);
    send_a($urandom, 0);
    send_a($urandom, 1);
    drain_a();

    for (int i = 0; i < 300; i++) begin
      if (!a.valid_i || acc != 0) begin
        a.valid_i = 1'($urandom);
        a.data_i = $urandom;
        a.mode_i = 1'($urandom);
      end
      a.ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = int'(a.valid_i && a.ready_o);
      @(posedge clk);
      #1;
    end
    a.valid_i = 0;
    a.ready_i = 1;
    drain_a();

    send_a($urandom, 0);
    send_a($urandom, 1);
    send_a($urandom, 0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("mrst_valid", a.valid_o, 0);
    chk("mrst_busy", a.busy_o, 0);
    chk("mrst_count", a.count_o, 0);
    acc = n_out;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_stale", n_out, acc);

    send_b(13'h1FFF, 0);
    lat_b(lat);
    chk("lat_b", lat, 3);
    chk("b_all_cnt", b.count_o, 13);
    chk("b_all_dat", b.data_o, 13'h1FFF);
    send_b(13'h0001, 0);
    lat_b(lat);
    chk("b_one_cnt", b.count_o, 1);
    send_b(13'h0001, 1);
    lat_b(lat);
    chk("b_zero_cnt", b.count_o, 12);
    repeat (4) @(posedge clk);
    #1;
    chk("b_idle", b.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
